// File: rtl/multiword_add_seq.sv
// multiword_add_seq
//
// Performs one W-bit addition (W = N*K) by reusing a single N-bit chunk adder
// over K clock cycles. The least-significant chunk is processed first, and the
// carry is chained from one chunk to the next. Operands arrive on a valid/ready
// input handshake. The sum and the c/o/z flags leave on a valid/ready output
// handshake.
//
// Optional build macro:
//   SUB_EN - when defined, in_sub is sampled at the accept edge and selects
//            x - y, computed as x + ~y + 1. When undefined, in_sub is ignored
//            and every operation is an add with carry-in 0.
//
// Parameters:
//   N - chunk width of the shared adder in bits (N >= 1)
//   K - number of chunks per operation (K >= 1)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   block can accept operands (IDLE only)
//   in_x       operand x, W bits
//   in_y       operand y, W bits
//   in_sub     subtract request (effective only with SUB_EN)
//   out_valid  result valid (DONE only)
//   out_ready  consumer accepts the result
//   out_s      sum, W bits
//   out_c      carry out of bit W-1 (no-borrow when subtracting)
//   out_o      signed overflow
//   out_z      out_s == 0
//   busy       high in RUN or DONE
module multiword_add_seq #(
  parameter int N = 4,
  parameter int K = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*K-1:0]   in_x,
  input  logic [N*K-1:0]   in_y,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*K-1:0]   out_s,
  output logic             out_c,
  output logic             out_o,
  output logic             out_z,
  output logic             busy
);

  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q;
  logic                   carry_q;

  // Operands and result are kept as chunk arrays so the running chunk can be
  // selected directly by the chunk counter.
  logic [K-1:0][N-1:0]    x_q;
  logic [K-1:0][N-1:0]    y_q;
  logic [K-1:0][N-1:0]    s_q;
  logic [K-1:0][N-1:0]    s_next;
  logic [N:0]             chunk_sum;
  logic                   last_chunk;
  logic                   sub_sel;

`ifdef SUB_EN
  assign sub_sel = in_sub;
`else
  logic unused_in_sub;
  assign unused_in_sub = in_sub;
  assign sub_sel       = 1'b0;
`endif

  assign out_s      = s_q;
  assign last_chunk = (cnt_q == CW'(K - 1));

  // One chunk of the add. s_next is the whole result with the current chunk
  // already merged in, so the final cycle can derive z and o from the
  // complete word before it is registered.
  always_comb begin
    chunk_sum       = {1'b0, x_q[cnt_q]} + {1'b0, y_q[cnt_q]} + {{N{1'b0}}, carry_q};
    s_next          = s_q;
    s_next[cnt_q]   = chunk_sum[N-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs. Retiring a result in DONE always passes
  // through IDLE, so no operation is accepted on the retirement edge.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_chunk) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath. Subtraction stores ~y and seeds the carry with 1. The carry out
  // of the top chunk only reaches out_c and is never fed back into chunk 0.
  // out_s and the flags hold their last values outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      out_c   <= 1'b0;
      out_o   <= 1'b0;
      out_z   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q     <= in_x;
            y_q     <= sub_sel ? ~in_y : in_y;
            carry_q <= sub_sel;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          s_q     <= s_next;
          carry_q <= chunk_sum[N];
          cnt_q   <= cnt_q + CW'(1);
          if (last_chunk) begin
            out_c <= chunk_sum[N];
            out_o <= ~(x_q[K-1][N-1] ^ y_q[K-1][N-1]) & (s_next[K-1][N-1] ^ x_q[K-1][N-1]);
            out_z <= (s_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_add_seq.sv
// tb_multiword_add_seq
//
// Self-checking bench for multiword_add_seq. The main instance uses N=4, K=4
// (W=16). A second instance uses N=16, K=1 to cover the single-cycle RUN
// case. Expected results come from a full-width reference model. They are
// queued when an operand pair is accepted and popped when the result appears.
module tb_multiword_add_seq;

  localparam int W = 16;
  localparam int K = 4;
`ifdef SUB_EN
  localparam bit SUB_BUILD = 1'b1;
`else
  localparam bit SUB_BUILD = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    logic         z;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;

  logic          in_valid = 1'b0, in_sub = 1'b0, out_ready = 1'b0;
  logic [W-1:0]  in_x = '0, in_y = '0;
  logic          in_ready, out_valid, out_c, out_o, out_z, busy;
  logic [W-1:0]  out_s;

  logic          k1_in_valid = 1'b0, k1_in_sub = 1'b0, k1_out_ready = 1'b0;
  logic [W-1:0]  k1_in_x = '0, k1_in_y = '0;
  logic          k1_in_ready, k1_out_valid, k1_out_c, k1_out_o, k1_out_z, k1_busy;
  logic [W-1:0]  k1_out_s;

  exp_t          exp_q[$];
  int            compared = 0;
  int            mismatched = 0;

  always #5 clk = ~clk;

  multiword_add_seq #(.N(4), .K(K)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s),
    .out_c(out_c), .out_o(out_o), .out_z(out_z), .busy(busy)
  );

  multiword_add_seq #(.N(16), .K(1)) dut_k1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(k1_in_valid), .in_ready(k1_in_ready), .in_x(k1_in_x), .in_y(k1_in_y), .in_sub(k1_in_sub),
    .out_valid(k1_out_valid), .out_ready(k1_out_ready), .out_s(k1_out_s),
    .out_c(k1_out_c), .out_o(k1_out_o), .out_z(k1_out_z), .busy(k1_busy)
  );

  // Full-width reference: subtraction is x + ~y + 1, and it applies only when
  // the build enables it.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub);
    exp_t         e;
    logic         s_eff;
    logic [W-1:0] yy;
    logic [W:0]   full;
    s_eff = sub & SUB_BUILD;
    yy    = s_eff ? ~y : y;
    full  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s_eff};
    e.s   = full[W-1:0];
    e.c   = full[W];
    e.o   = ~(x[W-1] ^ yy[W-1]) & (e.s[W-1] ^ x[W-1]);
    e.z   = (e.s == '0);
    return e;
  endfunction

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Present an operand pair, wait (bounded) for in_ready and let the next edge
  // accept it. Returns at the negedge just after the accept edge.
  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub);
    int n;
    in_x     = x;
    in_y     = y;
    in_sub   = sub;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkEq("accept in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    exp_q.push_back(model(x, y, sub));
    @(negedge clk);
    in_valid = 1'b0;
    checkEq("busy after accept", 32'(busy), 32'd1);
  endtask

  // Wait for the result, checking in_ready=0 and busy=1 through every RUN
  // cycle. Then compare against the scoreboard, optionally hold out_ready low,
  // and retire the result.
  task automatic checkOutput(input string tag, input int hold);
    int   lat;
    exp_t e;
    lat = 0;
    while (!out_valid && lat < 40) begin
      checkEq({tag, " run in_ready"}, 32'(in_ready), 32'd0);
      checkEq({tag, " run busy"}, 32'(busy), 32'd1);
      @(negedge clk);
      lat++;
    end
    checkEq({tag, " latency"}, 32'(lat), 32'(K));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    checkEq({tag, " out_s"}, 32'(out_s), 32'(e.s));
    checkEq({tag, " out_c"}, 32'(out_c), 32'(e.c));
    checkEq({tag, " out_o"}, 32'(out_o), 32'(e.o));
    checkEq({tag, " out_z"}, 32'(out_z), 32'(e.z));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkEq({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
      checkEq({tag, " hold out_s"}, 32'(out_s), 32'(e.s));
      checkEq({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkEq({tag, " retired out_valid"}, 32'(out_valid), 32'd0);
    checkEq({tag, " retired busy"}, 32'(busy), 32'd0);
    checkEq({tag, " retired out_s held"}, 32'(out_s), 32'(e.s));
  endtask

  // K=1 instance: the result must appear exactly one clock after accept.
  task automatic runK1(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    k1_in_x     = x;
    k1_in_y     = y;
    k1_in_valid = 1'b1;
    @(posedge clk);
    e = model(x, y, 1'b0);
    @(negedge clk);
    k1_in_valid = 1'b0;
    checkEq("k1 run out_valid", 32'(k1_out_valid), 32'd0);
    checkEq("k1 run busy", 32'(k1_busy), 32'd1);
    @(negedge clk);
    checkEq("k1 out_valid", 32'(k1_out_valid), 32'd1);
    checkEq("k1 out_s", 32'(k1_out_s), 32'(e.s));
    checkEq("k1 out_c", 32'(k1_out_c), 32'(e.c));
    checkEq("k1 out_o", 32'(k1_out_o), 32'(e.o));
    checkEq("k1 out_z", 32'(k1_out_z), 32'(e.z));
    k1_out_ready = 1'b1;
    @(negedge clk);
    k1_out_ready = 1'b0;
    checkEq("k1 retired in_ready", 32'(k1_in_ready), 32'd1);
  endtask

  initial begin
    // Reset values
    @(negedge clk);
    checkEq("reset in_ready", 32'(in_ready), 32'd1);
    checkEq("reset out_valid", 32'(out_valid), 32'd0);
    checkEq("reset busy", 32'(busy), 32'd0);
    checkEq("reset out_s", 32'(out_s), 32'd0);
    checkEq("reset flags", 32'({out_c, out_o, out_z}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Wrap to zero with carry
    applyStimulus(16'h0001, 16'hFFFF, 1'b0);
    checkOutput("wrap", 0);

    // Signed overflow
    applyStimulus(16'h7FFF, 16'h0001, 1'b0);
    checkOutput("ovf", 0);

    // Back-pressure, with a second request presented during RUN and DONE.
    // The operand lines change after accept and must not disturb the result.
    applyStimulus(16'h1234, 16'h1111, 1'b0);
    in_x     = 16'hABCD;
    in_y     = 16'h1111;
    in_valid = 1'b1;
    checkOutput("hold", 10);
    applyStimulus(16'hABCD, 16'h1111, 1'b0);
    checkOutput("after hold", 0);

    // Reset mid-RUN, after two chunk cycles
    applyStimulus(16'hFFFF, 16'h0001, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    checkEq("abort out_s", 32'(out_s), 32'd0);
    checkEq("abort flags", 32'({out_c, out_o, out_z}), 32'd0);
    checkEq("abort in_ready", 32'(in_ready), 32'd1);
    checkEq("abort busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkEq("abort no out_valid", 32'(out_valid), 32'd0);
    end
    applyStimulus(16'h0003, 16'h0004, 1'b0);
    checkOutput("post abort", 0);

    // Subtract requests (treated as adds when SUB_EN is not defined)
    applyStimulus(16'h0005, 16'h0007, 1'b1);
    checkOutput("sub borrow", 0);
    applyStimulus(16'h8000, 16'h0001, 1'b1);
    checkOutput("sub ovf", 0);

    // Single-chunk instance
    runK1(16'hFFFF, 16'h0001);
    runK1(16'h8000, 16'h8000);
    runK1(16'h1234, 16'h4321);

    checkEq("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
